upsample_stage: RTL and testbench

- Parametrised successor to the single-channel zero-insert stage in the DSP interpolation chain.
- Upsamples a multi-lane sample stream by a runtime-selectable integer rate.
- Two fill modes: zero insertion (feeds the interpolation FIR) and sample-and-hold.
- Registered output with full valid/ready backpressure. Sits between the decimated-rate processing and the interpolation filter.

---
 rtl/upsample_stage.sv | 141 ++++++++++++++
 tb/tb_upsample_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsample_stage.sv
`default_nettype none
// ============================================================================
//  Module   : upsample_stage
//  Purpose  : Multi-lane integer-rate upsampler with zero-insert or
//             sample-and-hold fill and a registered valid/ready output.
//  Revision : 1.0 - initial release
// ============================================================================
module upsample_stage #(
    parameter int G_DWIDTH   = 24,
    parameter int G_NUM_CH   = 2,
    parameter int G_MAX_RATE = 16,
    parameter int G_RWIDTH   = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [G_RWIDTH-1:0]          rate,
    input  logic                         mode,
    input  logic [G_NUM_CH*G_DWIDTH-1:0] din,
    input  logic                         din_valid,
    output logic                         din_ready,
    output logic [G_NUM_CH*G_DWIDTH-1:0] dout,
    output logic                         dout_valid,
    output logic                         dout_first,
    input  logic                         dout_ready
);

    localparam int C_W = G_NUM_CH * G_DWIDTH;

    localparam logic [G_RWIDTH-1:0] C_ONE      = G_RWIDTH'(1);
    localparam logic [G_RWIDTH-1:0] C_TWO      = G_RWIDTH'(2);
    localparam logic [G_RWIDTH-1:0] C_MAX_RATE = G_RWIDTH'(G_MAX_RATE);

    localparam logic [1:0] SM_IDLE = 2'd0;
    localparam logic [1:0] SM_DATA = 2'd1;
    localparam logic [1:0] SM_FILL = 2'd2;

    logic [1:0]          state_q,  state_d;
    logic [C_W-1:0]      dout_q,   dout_d;
    logic                valid_q,  valid_d;
    logic                first_q,  first_d;
    logic [C_W-1:0]      hold_q,   hold_d;
    logic [G_RWIDTH-1:0] rate_l_q, rate_l_d;
    logic                mode_l_q, mode_l_d;
    logic [G_RWIDTH-1:0] cnt_q,    cnt_d;

    logic                w_load_ok;
    logic                w_accept;
    logic [G_RWIDTH-1:0] w_eff;

    assign w_load_ok = !valid_q || dout_ready;
    assign din_ready = (state_q == SM_DATA) && w_load_ok;
    assign w_accept  = din_valid && din_ready;

    // Rates 0 and 1 both mean passthrough; anything above the maximum saturates.
    always_comb begin
        w_eff = rate;
        if (rate < C_TWO) begin
            w_eff = C_ONE;
        end else if (rate > C_MAX_RATE) begin
            w_eff = C_MAX_RATE;
        end
    end

    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        first_d  = first_q;
        hold_d   = hold_q;
        rate_l_d = rate_l_q;
        mode_l_d = mode_l_q;
        cnt_d    = cnt_q;

        case (state_q)
            SM_IDLE: begin
                state_d = SM_DATA;
            end
            SM_DATA: begin
                if (w_accept) begin
                    dout_d   = din;
                    first_d  = 1'b1;
                    valid_d  = 1'b1;
                    hold_d   = din;
                    rate_l_d = w_eff;
                    mode_l_d = mode;
                    cnt_d    = C_ONE;
                    if (w_eff > C_ONE) begin
                        state_d = SM_FILL;
                    end
                end else if (w_load_ok) begin
                    valid_d = 1'b0;
                end
            end
            SM_FILL: begin
                if (w_load_ok) begin
                    dout_d  = mode_l_q ? hold_q : '0;
                    first_d = 1'b0;
                    valid_d = 1'b1;
                    if (cnt_q == rate_l_q - C_ONE) begin
                        state_d = SM_DATA;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
            end
            default: begin
                state_d = SM_IDLE;
            end
        endcase
    end

    // Dropping enable behaves exactly like reset and discards any partial burst.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state_q  <= SM_IDLE;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            hold_q   <= '0;
            rate_l_q <= '0;
            mode_l_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            hold_q   <= hold_d;
            rate_l_q <= rate_l_d;
            mode_l_q <= mode_l_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_first = first_q;

endmodule
`default_nettype wire

// File: tb/tb_upsample_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_upsample_stage
//  Purpose  : Self-checking bench for upsample_stage with a beat-queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_upsample_stage;

    localparam int DW   = 24;
    localparam int NCH  = 2;
    localparam int MAXR = 16;
    localparam int RW   = 5;
    localparam int W    = DW * NCH;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [RW-1:0] rate;
    logic          mode;
    logic [W-1:0]  din;
    logic          din_valid;
    logic          din_ready;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          dout_first;
    logic          dout_ready;

    upsample_stage #(
        .G_DWIDTH   (DW),
        .G_NUM_CH   (NCH),
        .G_MAX_RATE (MAXR),
        .G_RWIDTH   (RW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .rate       (rate),
        .mode       (mode),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_first (dout_first),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         f;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    n_acc  = 0;
    int    n_out  = 0;

    // Model state: idle cycle after reset, beats of the burst still to be
    // produced, and whether the output register should be holding a beat.
    bit    m_known    = 1'b0;
    bit    m_idle     = 1'b1;
    bit    m_valid    = 1'b0;
    int    m_unloaded = 0;

    function automatic int eff_rate(input int r);
        if (r < 2)    return 1;
        if (r > MAXR) return MAXR;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [W-1:0] v;
        v[DW-1:0]   = DW'($urandom);
        v[W-1:DW]   = DW'($urandom);
        return v;
    endfunction

    task automatic tick();
        logic         rst_e, acc, ohs, p_rdy, p_valid, p_first;
        logic [W-1:0] p_dout, p_din;
        int           e;
        beat_t        b;

        @(negedge clk);
        rst_e   = reset || !enable;
        acc     = 1'b0;
        p_rdy   = dout_ready;
        p_valid = dout_valid;
        p_first = dout_first;
        p_dout  = dout;
        p_din   = din;

        if (m_known) begin
            chk("din_ready", W'(din_ready),
                W'(!m_idle && m_unloaded == 0 && (!m_valid || dout_ready)));
            chk("dout_valid", W'(dout_valid), W'(m_valid));
            acc = din_valid && din_ready;
            ohs = dout_valid && dout_ready;
            if (ohs) begin
                chk("beat_expected", W'(exp_q.size() > 0), W'(1'b1));
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    chk("dout", dout, b.d);
                    chk("dout_first", W'(dout_first), W'(b.f));
                    n_out++;
                end
            end
        end

        if (rst_e) begin
            exp_q.delete();
            m_known    = 1'b1;
            m_idle     = 1'b1;
            m_valid    = 1'b0;
            m_unloaded = 0;
        end else if (m_idle) begin
            m_idle  = 1'b0;
            m_valid = 1'b0;
        end else if (acc) begin
            n_acc++;
            e   = eff_rate(int'(rate));
            b.d = din;
            b.f = 1'b1;
            exp_q.push_back(b);
            for (int i = 1; i < e; i++) begin
                b.d = mode ? din : '0;
                b.f = 1'b0;
                exp_q.push_back(b);
            end
            m_unloaded = e - 1;
            m_valid    = 1'b1;
        end else if (!m_valid || p_rdy) begin
            if (m_unloaded > 0) begin
                m_unloaded--;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        if (rst_e) begin
            chk("rst_dout_valid", W'(dout_valid), '0);
            chk("rst_dout", dout, '0);
            chk("rst_dout_first", W'(dout_first), '0);
            chk("rst_din_ready", W'(din_ready), '0);
        end else begin
            if (p_valid === 1'b1 && !p_rdy) begin
                chk("stall_dout", dout, p_dout);
                chk("stall_first", W'(dout_first), W'(p_first));
                chk("stall_valid", W'(dout_valid), W'(1'b1));
            end
            if (acc) begin
                chk("lat_dout", dout, p_din);
                chk("lat_first", W'(dout_first), W'(1'b1));
            end
        end
    endtask

    initial begin
        int rl[3]   = '{0, 1, 20};
        int beats[3] = '{1, 1, 16};

        reset = 1'b1; enable = 1'b1; rate = 5'd4; mode = 1'b0;
        din = '0; din_valid = 1'b0; dout_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Rate 4 zero insert, lane 0 = 0x000123
        rate = 5'd4; mode = 1'b0; din = 48'h000000_000123; din_valid = 1'b1;
        n_out = 0;
        tick();
        din_valid = 1'b0;
        repeat (6) tick();
        chk("r4_beats", W'(n_out), W'(4));

        // Rate 3 hold with random backpressure, 200 inputs
        rate = 5'd3; mode = 1'b1; din = {24'h111111, 24'hABCDEF};
        n_acc = 0;
        for (int c = 0; c < 20000 && n_acc < 200; c++) begin
            din_valid  = ($urandom_range(0, 3) != 0);
            dout_ready = $urandom_range(0, 1) == 1;
            if (n_acc > 0) din = rnd_data();
            tick();
        end
        chk("r3_accepts", W'(n_acc), W'(200));
        din_valid = 1'b0; dout_ready = 1'b1;
        repeat (20) tick();
        chk("r3_drained", W'(exp_q.size()), '0);

        // Rates 0, 1 and 20 (saturating)
        for (int i = 0; i < 3; i++) begin
            rate = RW'(rl[i]); mode = 1'b1; din = rnd_data(); din_valid = 1'b1;
            n_out = 0;
            tick();
            din_valid = 1'b0;
            repeat (20) tick();
            chk("rate_beats", W'(n_out), W'(beats[i]));
        end

        // Rate 1 passthrough at full throughput
        rate = 5'd1; din_valid = 1'b1; n_acc = 0;
        repeat (10) begin
            din = rnd_data();
            tick();
        end
        chk("r1_throughput", W'(n_acc), W'(10));
        din_valid = 1'b0;
        repeat (4) tick();

        // Rate change from 2 to 5 mid-burst
        rate = 5'd2; mode = 1'b0; din = rnd_data(); din_valid = 1'b1; n_out = 0;
        tick();
        rate = 5'd5; din = rnd_data();
        tick();
        tick();
        din_valid = 1'b0;
        repeat (10) tick();
        chk("rate_change_beats", W'(n_out), W'(7));

        // Enable dropped after the 2nd beat of a rate-8 burst
        rate = 5'd8; mode = 1'b1; din = rnd_data(); din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        din = rnd_data(); din_valid = 1'b1;
        tick();
        chk("en_fresh_first", W'(dout_first), W'(1'b1));
        din_valid = 1'b0;
        repeat (10) tick();

        // Reset while stalled with a valid beat
        rate = 5'd4; mode = 1'b1; din = rnd_data(); din_valid = 1'b1;
        tick();
        din_valid = 1'b0; dout_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();

        // Mixed random traffic
        dout_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rate       = RW'($urandom_range(0, 31));
            mode       = $urandom_range(0, 1) == 1;
            din        = rnd_data();
            din_valid  = ($urandom_range(0, 2) != 0);
            dout_ready = ($urandom_range(0, 3) != 0);
            enable     = ($urandom_range(0, 79) != 0);
            reset      = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0; enable = 1'b1; din_valid = 1'b0; dout_ready = 1'b1;
        repeat (25) tick();
        chk("final_drained", W'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
